// File: rtl/multiplexor_display_pkg.sv
// Shared constants for the multiplexed 7-segment display driver.
// All segment patterns are active-low, bit 0 = segment a ... bit 6 = segment g.
package multiplexor_display_pkg;

    localparam int NUM_DIGITS = 4;

    // Anode pattern with every digit switched off (anodes are active-low).
    localparam logic [NUM_DIGITS-1:0] AN_OFF = 4'b1111;

    // Special segment patterns.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Decimal digit patterns, gfedcba ordering, active-low.
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;

    // Active-low one-hot anode select for a digit index.
    function automatic logic [NUM_DIGITS-1:0] anode_sel(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/multiplexor_display_decodificador_7seg.sv
// BCD to active-low 7-segment decoder. Codes 10-15 are not decimal digits
// and are shown as a single dash so bad data is visible on the display.
module decodificador_7seg
    import multiplexor_display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Pure lookup from digit code to segment pattern.
    always_comb begin
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/multiplexor_display.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// The active digit advances on each rising edge of the upstream counter MSB;
// the BCD value and decimal points are captured once per frame so a frame
// never mixes old and new digits.
// Optional feature macro: LEADING_ZERO_BLANK_EN blanks leading zero digits
// (digits 3..1); digit 0 always shows its value.
module multiplexor_display
    import multiplexor_display_pkg::*;
#(
    parameter int N = 18
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N-1:0]          q_cnt,
    input  logic                  en,
    input  logic [15:0]           bcd,
    input  logic [NUM_DIGITS-1:0] dp_en,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg,
    output logic                  dp
);

    logic                  msb_prev;
    logic                  tick;
    logic [1:0]            idx;
    logic [15:0]           snap;
    logic [NUM_DIGITS-1:0] snap_dp;
    logic [3:0]            digit;
    logic [6:0]            seg_dec;
    logic                  blank;
    logic [NUM_DIGITS-1:0] an_next;
    logic [6:0]            seg_next;
    logic                  dp_next;

    // Only the counter MSB matters; the lower bits are folded here so they
    // are visibly consumed.
    logic unused_cnt_bits;
    assign unused_cnt_bits = ^q_cnt[N-2:0];

    assign tick = q_cnt[N-1] & ~msb_prev;

    // Edge detector, digit index and per-frame snapshot.
    // NOTE: state registers use non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would let idx and snap race each other.
    always_ff @(posedge clk) begin
        if (!reset) begin
            msb_prev <= 1'b0;
            idx      <= 2'd0;
            snap     <= 16'h0000;
            snap_dp  <= '0;
        end else begin
            msb_prev <= q_cnt[N-1];
            if (tick && en) begin
                idx <= idx + 2'd1;
                // Reload on the same edge idx wraps 3 -> 0, so the new
                // frame starts with fresh, coherent data.
                if (idx == 2'd3) begin
                    snap    <= bcd;
                    snap_dp <= dp_en;
                end
            end
        end
    end

    assign digit = snap[{idx, 2'b00} +: 4];

    decodificador_7seg u_decoder (
        .bcd (digit),
        .seg (seg_dec)
    );

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] lead_zero;

    // A digit is a leading zero when it and every higher digit are zero.
    always_comb begin
        lead_zero    = '0;
        lead_zero[3] = (snap[15:12] == 4'd0);
        lead_zero[2] = lead_zero[3] & (snap[11:8] == 4'd0);
        lead_zero[1] = lead_zero[2] & (snap[7:4]  == 4'd0);
        lead_zero[0] = 1'b0;
    end

    assign blank = lead_zero[idx];
`else
    assign blank = 1'b0;
`endif

    // Next value of the output register for the currently selected digit.
    // NOTE: defaults are assigned first so every path drives every output
    // and no latch is inferred.
    always_comb begin
        an_next  = AN_OFF;
        seg_next = SEG_BLANK;
        dp_next  = 1'b1;
        if (en) begin
            an_next  = anode_sel(idx);
            seg_next = blank ? SEG_BLANK : seg_dec;
            dp_next  = ~snap_dp[idx];
        end
    end

    // Registered pin drivers; loaded every cycle so en acts on the next edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= an_next;
            seg <= seg_next;
            dp  <= dp_next;
        end
    end

endmodule

// File: tb/tb_multiplexor_display.sv
// Directed testbench for multiplexor_display with a 4-bit prescaler vector.
// Compile with +define+LEADING_ZERO_BLANK_EN to check leading-zero blanking.
module tb_multiplexor_display;

    localparam int N = 4;

    // Hand-written active-low patterns, gfedcba.
    localparam logic [6:0] S0    = 7'b1000000;
    localparam logic [6:0] S1    = 7'b1111001;
    localparam logic [6:0] S2    = 7'b0100100;
    localparam logic [6:0] S3    = 7'b0110000;
    localparam logic [6:0] S4    = 7'b0011001;
    localparam logic [6:0] S5    = 7'b0010010;
    localparam logic [6:0] S6    = 7'b0000010;
    localparam logic [6:0] S7    = 7'b1111000;
    localparam logic [6:0] S8    = 7'b0000000;
    localparam logic [6:0] S9    = 7'b0010000;
    localparam logic [6:0] DASH  = 7'b0111111;
    localparam logic [6:0] BLANK = 7'b1111111;
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] ZB = BLANK;  // a leading zero digit
`else
    localparam logic [6:0] ZB = S0;
`endif

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [N-1:0]   q_cnt = '0;
    logic           en = 1'b0;
    logic [15:0]    bcd = 16'h0000;
    logic [3:0]     dp_en = 4'b0000;
    logic [3:0]     an;
    logic [6:0]     seg;
    logic           dp;

    int n_cmp = 0;
    int n_bad = 0;

    multiplexor_display #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .q_cnt (q_cnt),
        .en    (en),
        .bcd   (bcd),
        .dp_en (dp_en),
        .an    (an),
        .seg   (seg),
        .dp    (dp)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] an_of(input int i);
        logic [3:0] a;
        a = 4'b1111;
        a[i] = 1'b0;
        return a;
    endfunction

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    // Lower counter bits carry junk to show they are ignored.
    task automatic set_msb(input logic v);
        q_cnt = {v, 3'b101};
    endtask

    // One MSB rising edge; returns when the new digit is on the pins.
    task automatic pulse();
        set_msb(1'b1);
        step();
        set_msb(1'b0);
        step();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        en    = 1'b1;
        bcd   = 16'h9876;
        dp_en = 4'b1111;
        set_msb(1'b1);
        repeat (3) step();
        n_cmp++;
        if (an !== 4'b1111 || seg !== BLANK || dp !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_hold: an=%b seg=%b dp=%b, expected an=1111 seg=%b dp=1", an, seg, dp, BLANK);
        end
        set_msb(1'b0);
        en    = 1'b0;
        reset = 1'b1;
        repeat (3) step();
        n_cmp++;
        if (an !== 4'b1111 || seg !== BLANK || dp !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_release: an=%b seg=%b dp=%b, expected an=1111 seg=%b dp=1", an, seg, dp, BLANK);
        end
    endtask

    task automatic test_scan();
        logic [6:0] pre [4] = '{S0, ZB, ZB, ZB};
        logic [6:0] fr  [4] = '{S4, S3, S2, S1};
        en    = 1'b1;
        bcd   = 16'h1234;
        dp_en = 4'b0100;
        step();
        // First frame still shows the reset snapshot (all zeros, no dp).
        for (int i = 0; i < 4; i++) begin
            if (i > 0) pulse();
            n_cmp++;
            if (an !== an_of(i) || seg !== pre[i] || dp !== 1'b1) begin
                n_bad++;
                $display("FAIL scan_pre%0d: an=%b seg=%b dp=%b, expected an=%b seg=%b dp=1", i, an, seg, dp, an_of(i), pre[i]);
            end
        end
        // Wrap edge: one cycle after the tick the pins still show digit 3.
        set_msb(1'b1);
        step();
        n_cmp++;
        if (an !== 4'b0111) begin
            n_bad++;
            $display("FAIL scan_latency: an=%b, expected 0111", an);
        end
        set_msb(1'b0);
        step();
        for (int i = 0; i < 4; i++) begin
            if (i > 0) pulse();
            n_cmp++;
            if (an !== an_of(i) || seg !== fr[i] || dp !== (i != 2)) begin
                n_bad++;
                $display("FAIL scan_frame%0d: an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b", i, an, seg, dp, an_of(i), fr[i], (i != 2));
            end
        end
        pulse();  // eighth rising edge: wrap, reload 1234
        n_cmp++;
        if (an !== 4'b1110 || seg !== S4 || dp !== 1'b1) begin
            n_bad++;
            $display("FAIL scan_wrap2: an=%b seg=%b dp=%b, expected an=1110 seg=%b dp=1", an, seg, dp, S4);
        end
    endtask

    task automatic test_coherence();
        logic [6:0] old_seg [4] = '{S4, S3, S2, S1};
        logic [6:0] new_seg [4] = '{S8, S7, S6, S5};
        pulse();  // idx 1
        bcd   = 16'h5678;
        dp_en = 4'b0000;
        for (int i = 2; i < 4; i++) begin
            pulse();
            n_cmp++;
            if (an !== an_of(i) || seg !== old_seg[i] || dp !== (i != 2)) begin
                n_bad++;
                $display("FAIL coherence_old%0d: an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b", i, an, seg, dp, an_of(i), old_seg[i], (i != 2));
            end
        end
        for (int i = 0; i < 4; i++) begin
            pulse();
            n_cmp++;
            if (an !== an_of(i) || seg !== new_seg[i] || dp !== 1'b1) begin
                n_bad++;
                $display("FAIL coherence_new%0d: an=%b seg=%b dp=%b, expected an=%b seg=%b dp=1", i, an, seg, dp, an_of(i), new_seg[i]);
            end
        end
    endtask

    task automatic test_invalid();
        logic [6:0] exp_seg [4] = '{S9, S0, DASH, DASH};
        bcd = 16'hFA09;
        for (int i = 0; i < 4; i++) begin
            pulse();
            n_cmp++;
            if (an !== an_of(i) || seg !== exp_seg[i] || dp !== 1'b1) begin
                n_bad++;
                $display("FAIL invalid%0d: an=%b seg=%b dp=%b, expected an=%b seg=%b dp=1", i, an, seg, dp, an_of(i), exp_seg[i]);
            end
        end
        // MSB held high for 20 cycles: exactly one step, 3 -> 0.
        set_msb(1'b1);
        repeat (10) step();
        n_cmp++;
        if (an !== 4'b1110 || seg !== S9) begin
            n_bad++;
            $display("FAIL held_mid: an=%b seg=%b, expected an=1110 seg=%b", an, seg, S9);
        end
        repeat (10) step();
        n_cmp++;
        if (an !== 4'b1110) begin
            n_bad++;
            $display("FAIL held_end: an=%b, expected 1110", an);
        end
        // Falling edge and the quiet cycles after it must not advance.
        set_msb(1'b0);
        repeat (4) step();
        n_cmp++;
        if (an !== 4'b1110 || seg !== S9) begin
            n_bad++;
            $display("FAIL falling_edge: an=%b seg=%b, expected an=1110 seg=%b", an, seg, S9);
        end
    endtask

    task automatic test_enable();
        pulse();
        pulse();  // idx 2
        n_cmp++;
        if (an !== 4'b1011 || seg !== DASH) begin
            n_bad++;
            $display("FAIL enable_pre: an=%b seg=%b, expected an=1011 seg=%b", an, seg, DASH);
        end
        en    = 1'b0;
        bcd   = 16'h1111;
        dp_en = 4'b1111;
        step();
        n_cmp++;
        if (an !== 4'b1111 || seg !== BLANK || dp !== 1'b1) begin
            n_bad++;
            $display("FAIL enable_off: an=%b seg=%b dp=%b, expected an=1111 seg=%b dp=1", an, seg, dp, BLANK);
        end
        repeat (5) pulse();
        n_cmp++;
        if (an !== 4'b1111 || seg !== BLANK || dp !== 1'b1) begin
            n_bad++;
            $display("FAIL enable_ticks_off: an=%b seg=%b dp=%b, expected an=1111 seg=%b dp=1", an, seg, dp, BLANK);
        end
        en = 1'b1;
        step();
        n_cmp++;
        if (an !== 4'b1011 || seg !== DASH || dp !== 1'b1) begin
            n_bad++;
            $display("FAIL enable_resume: an=%b seg=%b dp=%b, expected an=1011 seg=%b dp=1", an, seg, dp, DASH);
        end
        pulse();  // idx 3, still old snapshot
        n_cmp++;
        if (an !== 4'b0111 || seg !== DASH) begin
            n_bad++;
            $display("FAIL enable_idx3: an=%b seg=%b, expected an=0111 seg=%b", an, seg, DASH);
        end
        pulse();  // wrap picks up 1111 / dp 1111
        n_cmp++;
        if (an !== 4'b1110 || seg !== S1 || dp !== 1'b0) begin
            n_bad++;
            $display("FAIL enable_reload: an=%b seg=%b dp=%b, expected an=1110 seg=%b dp=0", an, seg, dp, S1);
        end
    endtask

    task automatic test_reset_mid();
        pulse();  // idx 1
        reset = 1'b0;
        step();
        n_cmp++;
        if (an !== 4'b1111 || seg !== BLANK || dp !== 1'b1) begin
            n_bad++;
            $display("FAIL midreset_blank: an=%b seg=%b dp=%b, expected an=1111 seg=%b dp=1", an, seg, dp, BLANK);
        end
        reset = 1'b1;
        step();
        n_cmp++;
        if (an !== 4'b1110 || seg !== S0 || dp !== 1'b1) begin
            n_bad++;
            $display("FAIL midreset_restart: an=%b seg=%b dp=%b, expected an=1110 seg=%b dp=1", an, seg, dp, S0);
        end
        pulse();
        n_cmp++;
        if (an !== 4'b1101 || seg !== ZB || dp !== 1'b1) begin
            n_bad++;
            $display("FAIL midreset_next: an=%b seg=%b dp=%b, expected an=1101 seg=%b dp=1", an, seg, dp, ZB);
        end
    endtask

    task automatic test_blanking();
        logic [6:0] exp_seg [4] = '{S0, S7, ZB, ZB};
        bcd   = 16'h0070;
        dp_en = 4'b0001;
        pulse();
        pulse();  // idx 3
        for (int i = 0; i < 4; i++) begin
            pulse();
            n_cmp++;
            if (an !== an_of(i) || seg !== exp_seg[i] || dp !== (i != 0)) begin
                n_bad++;
                $display("FAIL blanking%0d: an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b", i, an, seg, dp, an_of(i), exp_seg[i], (i != 0));
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_coherence();
        test_invalid();
        test_enable();
        test_reset_mid();
        test_blanking();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
